// File: rtl/apb_uart_slave.sv
// APB3 slave front-end for a UART core: decodes transfers into TX pushes, RX pops,
// status/control/baud register accesses, with one wait state per transfer.
module apb_uart_slave #(
    parameter logic [15:0] DEFAULT_DIV = 16'd163
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    input  logic        tx_full,
    output logic        rd_uart,
    input  logic [7:0]  r_data,
    input  logic        rx_empty,
    output logic [15:0] baud_div,
    output logic        uart_en,
    output logic        irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_BAUD   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [31:2]         addr_q, addr_n;
    logic                write_q, write_n;
    logic [15:0]         wdata_q, wdata_n;
    logic [CTRL_W-1:0]   ctrl, ctrl_n;
    logic                tx_drop, tx_drop_n;
    logic                rx_under, rx_under_n;
    logic [DATA_W-1:0]   prdata_n;
    logic                pready_n, pslverr_n, wr_n, rd_n, irq_n;
    logic [7:0]          w_data_n;
    logic [15:0]         baud_n;
    logic                addr_err;
    logic [2:0]          reg_idx;

    // Address bits and upper data bits that carry no meaning for this register map
    logic unused_bits;
    assign unused_bits = &{1'b0, PADDR[1:0], PWDATA[31:16]};

    assign reg_idx  = addr_q[4:2];
    assign addr_err = (|addr_q[31:5]) || (reg_idx > REG_BAUD);
    assign uart_en  = ctrl[0];

    // State, latched setup fields, registered outputs and config registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            ctrl     <= '0;
            tx_drop  <= 1'b0;
            rx_under <= 1'b0;
            PRDATA   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            wr_uart  <= 1'b0;
            rd_uart  <= 1'b0;
            w_data   <= '0;
            baud_div <= DEFAULT_DIV;
            irq      <= 1'b0;
        end else begin
            state    <= state_n;
            addr_q   <= addr_n;
            write_q  <= write_n;
            wdata_q  <= wdata_n;
            ctrl     <= ctrl_n;
            tx_drop  <= tx_drop_n;
            rx_under <= rx_under_n;
            PRDATA   <= prdata_n;
            PREADY   <= pready_n;
            PSLVERR  <= pslverr_n;
            wr_uart  <= wr_n;
            rd_uart  <= rd_n;
            w_data   <= w_data_n;
            baud_div <= baud_n;
            irq      <= irq_n;
        end
    end

    // Next-state, access decode and side effects
    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        write_n    = write_q;
        wdata_n    = wdata_q;
        ctrl_n     = ctrl;
        tx_drop_n  = tx_drop;
        rx_under_n = rx_under;
        prdata_n   = PRDATA;
        pready_n   = 1'b0;
        pslverr_n  = 1'b0;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        w_data_n   = w_data;
        baud_n     = baud_div;
        irq_n      = (ctrl[1] & ~rx_empty) | (ctrl[2] & ~tx_full);

        case (state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_n  = PADDR[31:2];
                    write_n = PWRITE;
                    wdata_n = PWDATA[15:0];
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_n = S_IDLE;
                end else if (PENABLE) begin
                    state_n  = S_DONE;
                    pready_n = 1'b1;
                    prdata_n = '0;
                    if (addr_err) begin
                        pslverr_n = 1'b1;
                    end else begin
                        case (reg_idx)
                            REG_TXDATA: begin
                                if (write_q) begin
                                    if (tx_full) begin
                                        pslverr_n = 1'b1;
                                        tx_drop_n = 1'b1;
                                    end else begin
                                        wr_n     = 1'b1;
                                        w_data_n = wdata_q[7:0];
                                    end
                                end
                            end
                            REG_RXDATA: begin
                                if (write_q) begin
                                    pslverr_n = 1'b1;
                                end else if (rx_empty) begin
                                    pslverr_n  = 1'b1;
                                    rx_under_n = 1'b1;
                                end else begin
                                    rd_n     = 1'b1;
                                    prdata_n = DATA_W'(r_data);
                                end
                            end
                            REG_STATUS: begin
                                if (write_q) begin
                                    tx_drop_n  = tx_drop  & ~wdata_q[2];
                                    rx_under_n = rx_under & ~wdata_q[3];
                                end else begin
                                    prdata_n = DATA_W'({rx_under, tx_drop, tx_full, rx_empty});
                                end
                            end
                            REG_CTRL: begin
                                if (write_q) ctrl_n = wdata_q[CTRL_W-1:0];
                                else         prdata_n = DATA_W'(ctrl);
                            end
                            REG_BAUD: begin
                                if (write_q) begin
                                    if (wdata_q == 16'd0) pslverr_n = 1'b1;
                                    else                  baud_n = wdata_q;
                                end else begin
                                    prdata_n = DATA_W'(baud_div);
                                end
                            end
                            default: pslverr_n = 1'b1;
                        endcase
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_uart_slave.sv
// Directed self-checking bench for apb_uart_slave: register map, error responses,
// strobe timing, abort and mid-transfer reset.
module tb_apb_uart_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        wr_uart, rd_uart;
    logic [7:0]  w_data;
    logic        tx_full, rx_empty;
    logic [7:0]  r_data;
    logic [15:0] baud_div;
    logic        uart_en, irq;

    int errs = 0;
    int n_checks = 0;

    // Samples taken during one transfer: T1, T2 and T3
    logic        s_rdy1, s_str1, s_rdy2, s_err2, s_wr2, s_rd2, s_tail3;
    logic [31:0] s_rdata2;
    logic [7:0]  s_wd2;
    logic [15:0] s_baud2;
    logic        bad;

    apb_uart_slave #(.DEFAULT_DIV(16'd163)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .wr_uart(wr_uart), .w_data(w_data),
        .tx_full(tx_full), .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
        .baud_div(baud_div), .uart_en(uart_en), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        s_rdy1 = PREADY; s_str1 = wr_uart | rd_uart;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        s_rdy2 = PREADY; s_err2 = PSLVERR; s_rdata2 = PRDATA;
        s_wr2 = wr_uart; s_rd2 = rd_uart; s_wd2 = w_data; s_baud2 = baud_div;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        s_tail3 = PREADY | PSLVERR | wr_uart | rd_uart;
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; tx_full = 1'b0; rx_empty = 1'b1; r_data = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", 32'(PREADY), 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_strobes", 32'({wr_uart, rd_uart}), 32'h0);
        chk("rst_w_data", 32'(w_data), 32'h0);
        chk("rst_baud", 32'(baud_div), 32'd163);
        chk("rst_en_irq", 32'({uart_en, irq}), 32'h0);

        // TX push
        apb(1'b1, 32'h00, 32'h0000_00A5);
        chk("tx_rdy_t1", 32'({s_rdy1, s_str1}), 32'h0);
        chk("tx_rdy_t2", 32'(s_rdy2), 32'h1);
        chk("tx_err", 32'(s_err2), 32'h0);
        chk("tx_wr", 32'({s_wr2, s_rd2}), 32'h2);
        chk("tx_wdata", 32'(s_wd2), 32'hA5);
        chk("tx_tail", 32'(s_tail3), 32'h0);

        // TX push while full is dropped
        tx_full = 1'b1;
        apb(1'b1, 32'h00, 32'h0000_005A);
        chk("txfull_err", 32'({s_rdy2, s_err2}), 32'h3);
        chk("txfull_wr", 32'(s_wr2), 32'h0);
        apb(1'b0, 32'h08, 32'h0);
        chk("stat_drop", s_rdata2, 32'h7);
        tx_full = 1'b0;

        // RX pop
        r_data = 8'h3C; rx_empty = 1'b0;
        apb(1'b0, 32'h04, 32'h0);
        chk("rx_data", s_rdata2, 32'h3C);
        chk("rx_rd", 32'({s_err2, s_wr2, s_rd2}), 32'h1);
        chk("rx_tail", 32'(s_tail3), 32'h0);

        // RX underflow
        rx_empty = 1'b1;
        apb(1'b0, 32'h04, 32'h0);
        chk("rxund_data", s_rdata2, 32'h0);
        chk("rxund_err", 32'({s_err2, s_rd2}), 32'h2);
        apb(1'b0, 32'h08, 32'h0);
        chk("stat_both", s_rdata2, 32'hD);

        // W1C sticky clear
        apb(1'b1, 32'h08, 32'h0000_000C);
        chk("w1c_err", 32'(s_err2), 32'h0);
        apb(1'b0, 32'h08, 32'h0);
        chk("stat_clr", s_rdata2, 32'h1);

        // Write to RXDATA is an error without pop
        rx_empty = 1'b0;
        apb(1'b1, 32'h04, 32'h0000_0011);
        chk("rxwr_err", 32'({s_err2, s_rd2, s_wr2}), 32'h4);
        rx_empty = 1'b1;

        // Baud divisor
        apb(1'b1, 32'h10, 32'h0000_001A);
        chk("baud_t2", 32'(s_baud2), 32'd26);
        chk("baud_err", 32'(s_err2), 32'h0);
        apb(1'b1, 32'h10, 32'h0);
        chk("baud0_err", 32'(s_err2), 32'h1);
        chk("baud0_keep", 32'(baud_div), 32'd26);
        apb(1'b0, 32'h10, 32'h0);
        chk("baud_rd", s_rdata2, 32'h1A);

        // Control and irq
        rx_empty = 1'b0;
        apb(1'b1, 32'h0C, 32'h0000_0003);
        chk("ctrl_en", 32'(uart_en), 32'h1);
        chk("ctrl_irq", 32'(irq), 32'h1);
        apb(1'b0, 32'h0C, 32'h0);
        chk("ctrl_rd", s_rdata2, 32'h3);
        rx_empty = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("irq_fall", 32'(irq), 32'h0);

        // Address decode errors
        apb(1'b0, 32'h14, 32'h0);
        chk("a14", {31'h0, s_err2} ^ s_rdata2, 32'h1);
        chk("a14_data", s_rdata2, 32'h0);
        apb(1'b1, 32'h0C, 32'h0000_0003);
        apb(1'b0, 32'h100, 32'h0);
        chk("a100_err", 32'(s_err2), 32'h1);
        chk("a100_data", s_rdata2, 32'h0);

        // TXDATA read returns zero with no error
        apb(1'b0, 32'h0C, 32'h0);
        apb(1'b0, 32'h00, 32'h0);
        chk("txrd", {s_rdata2[30:0], s_err2}, 32'h0);

        // Abort: PSEL dropped during the wait state
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (PREADY || wr_uart || PSLVERR) bad = 1'b1;
        end
        chk("abort_quiet", 32'(bad), 32'h0);
        apb(1'b0, 32'h0C, 32'h0);
        chk("abort_idle", 32'({s_rdy1, s_rdy2}), 32'h1);
        chk("abort_rd", s_rdata2, 32'h3);

        // Reset during T1 of a TX push
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h99;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (PREADY || wr_uart) bad = 1'b1;
        end
        chk("rstmid_nowr", 32'(bad), 32'h0);
        chk("rstmid_baud", 32'(baud_div), 32'd163);
        chk("rstmid_en", 32'(uart_en), 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        apb(1'b1, 32'h00, 32'h0000_0042);
        chk("post_rst_tx", 32'({s_wr2, s_wd2}), 32'h142);

        $display("Result: errors=%0d of %0d checks", errs, n_checks);
        $finish;
    end

endmodule
